// File: rtl/uart_out.sv
// uart_out: 8N1 MSB-first transmit-only serializer with an active-low valid/ready input.
module uart_out #(
   parameter int CDIV = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       n_valid,
   output logic       n_ready,
   input  logic [7:0] data,
   output logic       tx
);
   localparam int DW = CDIV > 1 ? $clog2(CDIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CDIV - 1);
   logic [7:0] shreg_q, shreg_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0] tx_index, tx_index_d;
   logic n_empty, n_empty_d, tx_q, tx_d;
   logic accept, bit_end;
   assign n_ready = n_empty;
   assign tx = tx_q;
   assign accept = !n_empty && !n_valid;
   assign bit_end = n_empty && div_q == DIV_LAST;
   // index 0 is the start bit; index 8 holds data[0], whose end drops back to idle
   always_comb begin
      shreg_d = shreg_q;
      div_d = div_q;
      tx_index_d = tx_index;
      n_empty_d = n_empty;
      tx_d = tx_q;
      if (accept) begin
         shreg_d = data;
         n_empty_d = 1'b1;
         tx_d = 1'b0;
         div_d = '0;
         tx_index_d = '0;
      end else if (bit_end) begin
         div_d = '0;
         if (tx_index == 4'd8) begin
            tx_d = 1'b1;
            n_empty_d = 1'b0;
            tx_index_d = '0;
         end else begin
            tx_d = shreg_q[7];
            shreg_d = {shreg_q[6:0], 1'b0};
            tx_index_d = tx_index + 4'd1;
         end
      end else if (n_empty) begin
         div_d = div_q + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (n_rst) begin
         shreg_q <= '0;
         div_q <= '0;
         tx_index <= '0;
         n_empty <= 1'b0;
         tx_q <= 1'b1;
      end else begin
         shreg_q <= shreg_d;
         div_q <= div_d;
         tx_index <= tx_index_d;
         n_empty <= n_empty_d;
         tx_q <= tx_d;
      end
   end
endmodule

// File: tb/tb_uart_out.sv
// tb_uart_out: scoreboard bench; stimulus queues expected bytes, a monitor checks each serial frame.
module tb_uart_out;
   localparam int CDIV = 2;
   logic clk = 1'b0;
   logic n_rst = 1'b1;
   logic n_valid = 1'b1;
   logic n_ready;
   logic [7:0] data = 8'h00;
   logic tx;
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   uart_out #(.CDIV(CDIV)) dut (
      .clk(clk), .n_rst(n_rst), .n_valid(n_valid), .n_ready(n_ready), .data(data), .tx(tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      while (n_ready !== 1'b0 && t < 40 * CDIV) begin
         @(negedge clk);
         t++;
      end
      if (n_ready !== 1'b0) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: n_ready=%b, expected 0 within %0d cycles", n_ready, 40 * CDIV);
      end else begin
         exp_q.push_back(b);
         data = b;
         n_valid = 1'b0;
         @(posedge clk);
         #1 n_valid = 1'b1;
         data = 8'h00;
      end
   endtask

   // monitor: a low tx on an idle line marks an accepted byte; check the whole frame against the queue
   initial begin
      logic [7:0] b;
      logic e;
      logic aborted;
      int s;
      forever begin
         @(negedge clk);
         if (!n_rst && tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_frame: start bit seen at %0t, expected idle line", $time);
               repeat (9 * CDIV) @(negedge clk);
            end else begin
               b = exp_q.pop_front();
               aborted = 1'b0;
               for (int k = 0; k < 9 * CDIV && !aborted; k++) begin
                  if (k > 0) @(negedge clk);
                  if (n_rst) aborted = 1'b1;
                  else begin
                     s = k / CDIV;
                     e = (s == 0) ? 1'b0 : b[8-s];
                     chk($sformatf("frame_%0h_tx_k%0d", b, k), {7'd0, tx}, {7'd0, e});
                     chk($sformatf("frame_%0h_busy_k%0d", b, k), {7'd0, dut.n_empty}, 8'd1);
                  end
               end
               if (!aborted) begin
                  @(negedge clk);
                  chk($sformatf("stop_%0h_tx", b), {7'd0, tx}, 8'd1);
                  chk($sformatf("stop_%0h_ready", b), {7'd0, n_ready}, 8'd0);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b0;
      @(negedge clk);
      chk("reset_tx", {7'd0, tx}, 8'd1);
      chk("reset_ready", {7'd0, n_ready}, 8'd0);
      chk("reset_empty", {7'd0, dut.n_empty}, 8'd0);
      @(posedge clk);
      @(negedge clk);
      chk("idle_no_accept_empty", {7'd0, dut.n_empty}, 8'd0);
      chk("idle_no_accept_tx", {7'd0, tx}, 8'd1);
      send(8'h53);
      send(8'h74);
      send(8'hA5);
      repeat (3 * CDIV) @(posedge clk);
      #1 n_valid = 1'b0;
      data = 8'hFF;
      @(posedge clk);
      #1 n_valid = 1'b1;
      data = 8'h00;
      repeat (12 * CDIV + 10) @(negedge clk);
      send(8'h3C);
      repeat (4 * CDIV) @(posedge clk);
      #1 chk("mid_frame_index", {4'd0, dut.tx_index}, 8'd4);
      n_rst = 1'b1;
      @(posedge clk);
      #1 n_rst = 1'b0;
      @(negedge clk);
      chk("abort_tx", {7'd0, tx}, 8'd1);
      chk("abort_ready", {7'd0, n_ready}, 8'd0);
      chk("abort_empty", {7'd0, dut.n_empty}, 8'd0);
      send(8'h81);
      repeat (12 * CDIV + 10) @(negedge clk);
      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
